// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage controller for the HI/LO multiply/divide path.
// Converts signed operands to magnitudes, sequences an external unsigned
// multiplier or divider, applies sign correction and owns HI/LO.
//
// Unit handshake: the controller raises <unit>_valid with stable operands
// and keeps it high until it samples <unit>_done == 1 on a rising edge,
// which is also the edge at which <unit>_c is captured. The unit keeps
// done low in the cycle it accepts valid, and reports done == 1 while idle
// with no request, which lets DRAIN finish whether or not the unit had
// started. Only one unit's valid is ever high.
module muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [2:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic                advance,
  input  logic                flush,
  output logic                stall,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic                mul_valid,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_c,
  output logic                div_valid,
  output logic [DATA_W-1:0]   div_a,
  output logic [DATA_W-1:0]   div_b,
  input  logic                div_done,
  input  logic [2*DATA_W-1:0] div_c,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t state_q, state_d;

  // Latched operation context: magnitudes, sign fixes, which unit is in use.
  logic [DATA_W-1:0]   a_q, b_q;
  logic                negq_q, negr_q;
  logic                unit_div_q;
  logic [2*DATA_W-1:0] res_q;
  logic [DATA_W-1:0]   hi_q, lo_q;

  // Request decode.
  logic                is_arith, is_signed, is_divop, b_zero;
  logic [DATA_W-1:0]   a_mag, b_mag;

  // Control strobes from the next-state logic.
  logic                launch, capture, fix_we, mthi_we, mtlo_we;

  // Decode the execute-stage request and form operand magnitudes.
  always_comb begin
    is_arith  = req_valid && ((req_op == OP_MULT) || (req_op == OP_MULTU) ||
                              (req_op == OP_DIV)  || (req_op == OP_DIVU));
    is_signed = (req_op == OP_MULT) || (req_op == OP_DIV);
    is_divop  = (req_op == OP_DIV) || (req_op == OP_DIVU);
    b_zero    = (req_b == '0);
    // Two's complement negation leaves the most negative value unchanged,
    // which is exactly its magnitude when read as unsigned.
    a_mag     = (is_signed && req_a[DATA_W-1]) ? -req_a : req_a;
    b_mag     = (is_signed && req_b[DATA_W-1]) ? -req_b : req_b;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, stall and unit-request logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mul_valid = 1'b0;
    div_valid = 1'b0;
    launch    = 1'b0;
    capture   = 1'b0;
    fix_we    = 1'b0;
    mthi_we   = 1'b0;
    mtlo_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = is_arith;
        if (!flush) begin
          if (is_arith) begin
            launch = 1'b1;
            if (is_divop && b_zero) state_d = S_DONE;
            else if (is_divop)      state_d = S_DIV;
            else                    state_d = S_MUL;
          end else if (req_valid && (req_op == OP_MTHI)) begin
            mthi_we = 1'b1;
          end else if (req_valid && (req_op == OP_MTLO)) begin
            mtlo_we = 1'b1;
          end
        end
      end
      S_MUL: begin
        stall     = 1'b1;
        mul_valid = 1'b1;
        if (flush) begin
          state_d = S_DRAIN;
        end else if (mul_done) begin
          capture = 1'b1;
          state_d = S_FIX;
        end
      end
      S_DIV: begin
        stall     = 1'b1;
        div_valid = 1'b1;
        if (flush) begin
          state_d = S_DRAIN;
        end else if (div_done) begin
          capture = 1'b1;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          fix_we  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for the instruction to leave execute so it cannot relaunch.
        if (flush || advance) state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall = is_arith;
        if (unit_div_q ? div_done : mul_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand, sign-flag and raw-result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      unit_div_q <= 1'b0;
      res_q      <= '0;
    end else begin
      if (launch) begin
        a_q        <= a_mag;
        b_q        <= b_mag;
        negq_q     <= is_signed && (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
        negr_q     <= is_signed && req_a[DATA_W-1];
        unit_div_q <= is_divop;
      end
      if (capture) res_q <= unit_div_q ? div_c : mul_c;
    end
  end

  // HI/LO: sign-corrected result commit in FIX, or direct MTHI/MTLO write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_we) begin
      if (unit_div_q) begin
        lo_q <= negq_q ? -res_q[DATA_W-1:0] : res_q[DATA_W-1:0];
        hi_q <= negr_q ? -res_q[2*DATA_W-1:DATA_W] : res_q[2*DATA_W-1:DATA_W];
      end else begin
        {hi_q, lo_q} <= negq_q ? -res_q : res_q;
      end
    end else begin
      if (mthi_we) hi_q <= req_a;
      if (mtlo_we) lo_q <= req_a;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign dbg_state = state_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage controller for the HI/LO multiply/divide path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute and does the signed-magnitude conversion.
- Sequences the external multicycle multiplier (c = a*b, unsigned) and divider (c = {a%b, a/b}, unsigned) over valid/done handshakes.
- Applies sign correction, owns the HI/LO registers, and stalls the pipeline until the result is committed.

Parameters:
- DATA_W, 32, operand width; HI/LO width; unit result width = 2*DATA_W.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  execute stage presents an op this cycle
- req_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NONE
- req_a  in  DATA_W  rs operand
- req_b  in  DATA_W  rt operand
- advance  in  1  execute stage moves its instruction forward this cycle
- flush  in  1  kill in-flight op (exception/branch squash)
- stall  out  1  hold execute stage
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- mul_valid  out  1  multiplier request
- mul_a, mul_b  out  DATA_W  multiplier operands (magnitudes)
- mul_done  in  1  multiplier done
- mul_c  in  2*DATA_W  product
- div_valid  out  1  divider request
- div_a, div_b  out  DATA_W  divider operands (magnitudes)
- div_done  in  1  divider done
- div_c  in  2*DATA_W  {remainder, quotient}

Behaviour:
- Reset: state IDLE; hi = lo = 0; mul_valid = div_valid = 0; stall = 0; operand registers and sign flags = 0.
- States: IDLE, MUL, DIV, FIX, DONE, DRAIN.
- Arith op = MULT/MULTU/DIV/DIVU.
- IDLE, req_valid & arith op:
  - stall = 1 (combinational).
  - Latch |a| and |b|. Signed ops negate when bit 31 is set; 0x80000000 maps to 0x80000000.
  - Latch neg_q = a[31]^b[31] and neg_r = a[31] (signed ops only).
  - Go to MUL, or DIV.
  - DIV/DIVU with b == 0 goes straight to DONE: no unit launch, HI/LO unchanged.
- IDLE, req_valid & MTHI/MTLO: hi (resp. lo) <= req_a at the edge; no stall; the write repeats while held, which is harmless.
- MUL / DIV:
  - Drive the unit's valid = 1 with stable latched operands; stall = 1.
  - Leave on that unit's done == 1 and capture c. The unit holds done low in the cycle it accepts valid, so no mask is needed.
  - No assumption on unit latency.
- FIX: stall = 1; registered write of HI/LO.
  - Multiply: {hi, lo} <= neg_q ? -c : c (64-bit two's complement).
  - Divide: lo <= neg_q ? -c[31:0] : c[31:0]; hi <= neg_r ? -c[63:32] : c[63:32].
  - Unsigned ops: neg flags = 0.
- DONE: stall = 0. Leave for IDLE on advance = 1, otherwise hold. This prevents a held instruction from relaunching.
- Latency from MULT accept (cycle 0):
  - MUL cycles 1–2 (mul_done in cycle 2), FIX cycle 3.
  - HI/LO visible and stall low in cycle 4.
  - Divide: 1 + (cycles until div_done) + 1 FIX.
- flush, highest priority, takes effect at the edge:
  - From MUL/DIV: drop valid and go to DRAIN. HI/LO are never written for a flushed op.
  - From FIX/DONE/IDLE: go to IDLE. A FIX in the same cycle as flush is suppressed.
  - MTHI/MTLO with flush is not written.
- DRAIN: valid = 0; stall = 1 only if req_valid & arith op; go to IDLE on the drained unit's done. A unit already in INIT reports done = 1 immediately.
- Only one unit is active at a time; mul_valid and div_valid are never both 1.
- reset asserted mid-operation returns to IDLE asynchronously and clears HI/LO. The units are reset by the same domain.

Test Plan:
- Reset: assert reset mid-DIV -> hi = lo = 0, stall = 0, div_valid = 0 immediately.
- MULT a = 0xFFFFFFFE (-2), b = 3, advance tied 1:
  - stall high in cycles 0–3.
  - Cycle 4: hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; mul_a/mul_b = 0xFFFFFFFF.
- DIV:
  - -7/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
  - DIVU 7/0 -> no div_valid; HI/LO unchanged; DONE after 1 cycle.
- Flush: flush during DIV state at cycle 5 -> DRAIN. A new MULT request stalls until div_done, then runs. HI/LO reflect only the MULT.
- MTHI 0x1234 then MTLO 0x5678 back to back, no stall -> hi = 0x1234, lo = 0x5678. Hold advance = 0 in DONE for 3 cycles -> no relaunch.
